operand_issue: RTL and testbench

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/operand_issue_pkg.sv | 8 +
 rtl/operand_scoreboard.sv | 35 +++
 rtl/operand_issue.sv | 109 ++++++++++
 tb/tb_operand_issue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_issue_pkg.sv
// Shared types and default widths for the operand issue stage.
package operand_issue_pkg;
   localparam int WORD_SIZE_DEF     = 64;
   localparam int REG_ADDR_SIZE_DEF = 4;
   localparam int OP_SIZE_DEF       = 8;

   typedef enum logic [1:0] {IDLE, CHECK, READ, VALID} state_t;
endpackage

// File: rtl/operand_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, looked up for hazards.
module operand_scoreboard import operand_issue_pkg::*; #(
   parameter int REG_ADDR_SIZE = REG_ADDR_SIZE_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     set_en,
   input  logic [REG_ADDR_SIZE-1:0] set_idx,
   input  logic                     clr_en,
   input  logic [REG_ADDR_SIZE-1:0] clr_idx,
   input  logic [REG_ADDR_SIZE-1:0] rs1,
   input  logic [REG_ADDR_SIZE-1:0] rs2,
   input  logic [REG_ADDR_SIZE-1:0] rd,
   output logic                     hazard
);
   localparam int NREG = 1 << REG_ADDR_SIZE;

   // r0 has no storage, so it can never report busy.
   logic [NREG-1:1] busy_q;
   logic [NREG-1:0] busy;
   assign busy = {busy_q, 1'b0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (set_en && set_idx == REG_ADDR_SIZE'(i))      busy_q[i] <= 1'b1;
            else if (clr_en && clr_idx == REG_ADDR_SIZE'(i)) busy_q[i] <= 1'b0;
         end
      end
   end

   assign hazard = busy[rs1] | busy[rs2] | busy[rd];
endmodule

// File: rtl/operand_issue.sv
// Operand issue stage: hazard check against the scoreboard, register-file read, ALU handoff.
module operand_issue import operand_issue_pkg::*; #(
   parameter int WORD_SIZE     = WORD_SIZE_DEF,
   parameter int REG_ADDR_SIZE = REG_ADDR_SIZE_DEF,
   parameter int OP_SIZE       = OP_SIZE_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OP_SIZE-1:0]       in_op,
   input  logic [REG_ADDR_SIZE-1:0] in_rd,
   input  logic [REG_ADDR_SIZE-1:0] in_rs1,
   input  logic [REG_ADDR_SIZE-1:0] in_rs2,
   output logic                     rf_en,
   output logic [REG_ADDR_SIZE-1:0] rf_write,
   output logic [REG_ADDR_SIZE-1:0] rf_r1,
   output logic [REG_ADDR_SIZE-1:0] rf_r2,
   output logic [WORD_SIZE-1:0]     rf_data,
   input  logic [WORD_SIZE-1:0]     rf_out1,
   input  logic [WORD_SIZE-1:0]     rf_out2,
   input  logic                     wb_valid,
   input  logic [REG_ADDR_SIZE-1:0] wb_rd,
   input  logic [WORD_SIZE-1:0]     wb_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OP_SIZE-1:0]       out_op,
   output logic [REG_ADDR_SIZE-1:0] out_rd,
   output logic [WORD_SIZE-1:0]     out_a,
   output logic [WORD_SIZE-1:0]     out_b,
   output logic [15:0]              stall_cnt
);
   state_t                   state;
   logic [OP_SIZE-1:0]       cap_op;
   logic [REG_ADDR_SIZE-1:0] cap_rd, cap_rs1, cap_rs2;
   logic                     hazard, grant, accept;

   assign in_ready = (state == IDLE) || (state == VALID && out_ready);
   assign accept   = in_valid && in_ready;
   assign grant    = (state == CHECK) && !hazard;

   assign rf_en    = rst_n;
   assign rf_r1    = cap_rs1;
   assign rf_r2    = cap_rs2;
   assign rf_write = wb_valid ? wb_rd : '0;
   assign rf_data  = wb_data;

   operand_scoreboard #(.REG_ADDR_SIZE(REG_ADDR_SIZE)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_en  (grant && cap_rd != '0),
      .set_idx (cap_rd),
      .clr_en  (wb_valid),
      .clr_idx (wb_rd),
      .rs1     (cap_rs1),
      .rs2     (cap_rs2),
      .rd      (cap_rd),
      .hazard  (hazard)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cap_op    <= '0;
         cap_rd    <= '0;
         cap_rs1   <= '0;
         cap_rs2   <= '0;
         out_valid <= 1'b0;
         out_op    <= '0;
         out_rd    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         stall_cnt <= '0;
      end else begin
         if (accept) begin
            cap_op  <= in_op;
            cap_rd  <= in_rd;
            cap_rs1 <= in_rs1;
            cap_rs2 <= in_rs2;
         end
         case (state)
            IDLE:  if (in_valid) state <= CHECK;
            CHECK: begin
               if (hazard) begin
                  if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
               end else begin
                  state <= READ;
               end
            end
            // rf_out* settled at the mid-cycle negedge; capture them with the op.
            READ: begin
               out_a     <= rf_out1;
               out_b     <= rf_out2;
               out_op    <= cap_op;
               out_rd    <= cap_rd;
               out_valid <= 1'b1;
               state     <= VALID;
            end
            VALID: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= in_valid ? CHECK : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with an external register-file model and an issue-order scoreboard.
module tb_operand_issue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [7:0]  in_op;
   logic [3:0]  in_rd, in_rs1, in_rs2;
   logic        rf_en;
   logic [3:0]  rf_write, rf_r1, rf_r2;
   logic [63:0] rf_data, rf_out1, rf_out2;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [63:0] wb_data;
   logic        out_valid, out_ready;
   logic [7:0]  out_op;
   logic [3:0]  out_rd;
   logic [63:0] out_a, out_b;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   operand_issue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .rf_en(rf_en), .rf_write(rf_write), .rf_r1(rf_r1), .rf_r2(rf_r2),
      .rf_data(rf_data), .rf_out1(rf_out1), .rf_out2(rf_out2),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
      .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .stall_cnt(stall_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // External register file: write at posedge, read data settles at negedge, r0 hardwired.
   logic [63:0] rf [16] = '{1: 64'h5, 2: 64'h7, 5: 64'h55, 10: 64'hA0, default: 64'h0};
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rf_en && rf_write != 4'd0) rf[rf_write] <= rf_data;
   end
   always @(negedge clk) begin
      rf_out1 <= rf[rf_r1];
      rf_out2 <= rf[rf_r2];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: instructions leave in acceptance order with operands equal to the
   // register contents once hazards resolve; a held output must not move.
   typedef struct { logic [7:0] op; logic [3:0] rd, rs1, rs2; } ins_t;
   ins_t        exp_q[$];
   logic        pv, pr;
   logic [7:0]  p_op;
   logic [3:0]  p_rd;
   logic [63:0] p_a, p_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pv <= 1'b0;
         pr <= 1'b1;
      end else begin
         chk("rf_en_high", 64'(rf_en), 64'h1);
         if (pv && !pr) begin
            chk("hold_valid", 64'(out_valid), 64'h1);
            chk("hold_a", out_a, p_a);
            chk("hold_b", out_b, p_b);
            chk("hold_op_rd", 64'({out_op, out_rd}), 64'({p_op, p_rd}));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL spurious_issue: got op %0h expected none", out_op);
            end else begin
               chk("model_op", 64'(out_op), 64'(exp_q[0].op));
               chk("model_rd", 64'(out_rd), 64'(exp_q[0].rd));
               chk("model_a", out_a, rf[exp_q[0].rs1]);
               chk("model_b", out_b, rf[exp_q[0].rs2]);
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back('{in_op, in_rd, in_rs1, in_rs2});
         pv <= out_valid; pr <= out_ready;
         p_op <= out_op; p_rd <= out_rd; p_a <= out_a; p_b <= out_b;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, output int acc);
      int n = 0;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      @(negedge clk);
      while (!in_ready && n < 30) begin @(negedge clk); n++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 (op %0h)", op);
      end
      @(posedge clk); #1;
      acc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int at);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 30) begin @(negedge clk); n++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL valid_timeout: got out_valid 0 expected 1");
         at = -1;
      end else begin
         at = cyc;
      end
   endtask

   initial begin
      int acc, at, h, s0;
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_stall", 64'(stall_cnt), 64'h0);
      chk("rst_rf_en", 64'(rf_en), 64'h0);
      chk("rst_out_a", out_a, 64'h0);
      chk("rst_rf_r1", 64'(rf_r1), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      rst_n = 1'b1;
      tick();

      // Basic issue: out_valid visible after edge k+2, taken at edge k+3.
      issue(8'h11, 4'd3, 4'd1, 4'd2, acc);
      wait_valid(at);
      chk("lat_basic", 64'(at), 64'(acc + 2));
      chk("basic_a", out_a, 64'h5);
      chk("basic_b", out_b, 64'h7);
      chk("basic_rd", 64'(out_rd), 64'h3);
      chk("basic_op", 64'(out_op), 64'h11);
      tick();

      // RAW on r3 stalls until writeback, then reads the new value.
      issue(8'h22, 4'd5, 4'd3, 4'd2, acc);
      repeat (4) tick();
      chk("raw_stall4", 64'(stall_cnt), 64'h4);
      chk("raw_no_valid", 64'(out_valid), 64'h0);
      wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 64'h99;
      #1;
      chk("wb_rf_write", 64'(rf_write), 64'h3);
      chk("wb_rf_data", rf_data, 64'h99);
      tick(); h = cyc; wb_valid = 1'b0;
      wait_valid(at);
      chk("raw_lat", 64'(at), 64'(h + 2));
      chk("raw_a", out_a, 64'h99);
      chk("raw_stall5", 64'(stall_cnt), 64'h5);
      tick();

      // r0 never busy; writeback to r0 leaves it zero.
      wb_valid = 1'b1; wb_rd = 4'd0; wb_data = 64'hDEAD;
      #1;
      chk("wb0_rf_write", 64'(rf_write), 64'h0);
      tick(); wb_valid = 1'b0;
      s0 = int'(stall_cnt);
      issue(8'h33, 4'd0, 4'd1, 4'd2, acc);
      wait_valid(at);
      chk("r0_lat1", 64'(at), 64'(acc + 2));
      tick();
      issue(8'h44, 4'd6, 4'd0, 4'd0, acc);
      wait_valid(at);
      chk("r0_lat2", 64'(at), 64'(acc + 2));
      chk("r0_a", out_a, 64'h0);
      chk("r0_b", out_b, 64'h0);
      chk("r0_no_stall", 64'(stall_cnt), 64'(s0));
      tick();

      // Backpressure for 5 cycles, then back-to-back acceptance on release.
      out_ready = 1'b0;
      issue(8'h55, 4'd7, 4'd1, 4'd2, acc);
      wait_valid(at);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 0) begin
            in_valid = 1'b1; in_op = 8'h66; in_rd = 4'd8; in_rs1 = 4'd2; in_rs2 = 4'd1;
         end
         chk("bp_valid", 64'(out_valid), 64'h1);
         chk("bp_a", out_a, 64'h5);
         chk("bp_op", 64'(out_op), 64'h55);
         chk("bp_in_ready", 64'(in_ready), 64'h0);
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", 64'(in_ready), 64'h1);
      tick(); h = cyc; in_valid = 1'b0;
      chk("b2b_drop", 64'(out_valid), 64'h0);
      wait_valid(at);
      chk("b2b_lat", 64'(at), 64'(h + 2));
      chk("b2b_a", out_a, 64'h7);
      chk("b2b_b", out_b, 64'h5);
      chk("b2b_rd", 64'(out_rd), 64'h8);
      tick();

      // Same-edge set and clear of r4: the set wins, so a reader of r4 stalls.
      issue(8'h77, 4'd4, 4'd1, 4'd2, acc);
      wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 64'h44;
      tick(); wb_valid = 1'b0;
      wait_valid(at);
      tick();
      s0 = int'(stall_cnt);
      issue(8'h88, 4'd9, 4'd4, 4'd0, acc);
      repeat (3) tick();
      chk("setwin_stall", 64'(stall_cnt), 64'(s0 + 3));
      chk("setwin_no_valid", 64'(out_valid), 64'h0);
      wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 64'h4444;
      tick(); wb_valid = 1'b0;
      wait_valid(at);
      chk("setwin_a", out_a, 64'h4444);
      tick();

      // Reset while in READ discards the instruction and all busy bits.
      issue(8'h99, 4'd10, 4'd1, 4'd2, acc);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'h0);
      chk("mid_rst_stall", 64'(stall_cnt), 64'h0);
      chk("mid_rst_rf_en", 64'(rf_en), 64'h0);
      chk("mid_rst_rf_r1", 64'(rf_r1), 64'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      issue(8'hAA, 4'd11, 4'd10, 4'd5, acc);
      wait_valid(at);
      chk("post_rst_lat", 64'(at), 64'(acc + 2));
      chk("post_rst_a", out_a, 64'hA0);
      chk("post_rst_b", out_b, 64'h55);
      chk("post_rst_stall", 64'(stall_cnt), 64'h0);
      tick();
      tick();
      chk("queue_drained", 64'(exp_q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
